gamepad_event_gen: RTL and testbench
====================================

GAMEPAD_EVENT_GEN -- requirements
Module: gamepad_event_gen

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 12, number of button lanes (index order B,Y,SELECT,START,UP,DOWN,LEFT,RIGHT,A,X,L,R).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 2, consecutive differing frames (1..3) needed to change the debounced state.
REQ-003 SHALL have parameter REPEAT_DELAY, default 30, frames from press to first repeat (1..63).
REQ-004 SHALL have parameter REPEAT_RATE, default 6, frames between subsequent repeats (1..63).
REQ-005 clk  input  1  clock.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 buttons_raw  input  NUM_BUTTONS  raw button levels from the Pmod decoder, 1 = pressed.
REQ-008 is_present  input  1  controller detected; when low, all raw buttons are treated as 0.
REQ-009 frame_tick  input  1  single-cycle pulse, once per video frame.
REQ-010 btn_state  output  NUM_BUTTONS  debounced levels.
REQ-011 btn_pressed  output  NUM_BUTTONS  buttons whose debounced level rose this frame.
REQ-012 btn_released  output  NUM_BUTTONS  buttons whose debounced level fell this frame.
REQ-013 btn_repeat  output  NUM_BUTTONS  auto-repeat events this frame.
REQ-014 events_valid  output  1  single-cycle pulse when all event vectors update.
REQ-015 overrun  output  1  single-cycle pulse when frame_tick arrives while busy.

Function
REQ-016 SHALL sample (buttons_raw & {NUM_BUTTONS{is_present}}) into a snapshot on the cycle frame_tick is high and the block is idle (tick cycle T).
REQ-017 SHALL process one button per cycle, index 0 at T+1 through index NUM_BUTTONS-1 at T+NUM_BUTTONS, via a two-state controller: IDLE, SCAN.
REQ-018 SHALL assert events_valid at T+NUM_BUTTONS+1 and update btn_state/btn_pressed/btn_released/btn_repeat on that same cycle; all four vectors SHALL hold until the next events_valid.
REQ-019 Debounce per button: raw==stable clears deb_cnt; otherwise deb_cnt+1; when deb_cnt+1==DEBOUNCE_FRAMES, stable<=raw and deb_cnt<=0.
REQ-020 Stable 0->1: pressed=1, repeat state DELAY, rep_cnt=0.
REQ-021 Stable 1->0: released=1, repeat state IDLE, rep_cnt=0, and no repeat event that frame.
REQ-022 DELAY and held: rep_cnt+1; when it reaches REPEAT_DELAY, repeat=1, state REPEAT, rep_cnt=0.
REQ-023 REPEAT and held: rep_cnt+1; when it reaches REPEAT_RATE, repeat=1, rep_cnt=0.
REQ-024 pressed and repeat SHALL never both be 1 for a button in one frame.
REQ-025 rep_cnt SHALL be 6 bits; deb_cnt SHALL be 2 bits; neither SHALL wrap.
REQ-026 frame_tick during SCAN or on the events_valid cycle SHALL be ignored, with overrun pulsed on that cycle; state SHALL be unchanged.
REQ-027 buttons_raw/is_present changes during SCAN SHALL not affect the current frame.

Reset
REQ-028 On rst_n low at a clock edge: controller IDLE; all stable, deb_cnt, and rep_cnt cleared; repeat states IDLE; all outputs 0; a scan in progress SHALL be abandoned without emitting events_valid.
REQ-029 frame_tick coincident with reset SHALL be ignored.

Structure
REQ-030 SHALL place button index constants, the repeat-state encoding (IDLE/DELAY/REPEAT), and the counter widths in shared package gamepad_pkg.
REQ-031 SHALL hold per-button state in register arrays indexed by the scan counter, so that only one update datapath exists.
REQ-032 The single per-button update datapath SHALL be the combinational sub-module gamepad_btn_update (current state + raw in; next state + pressed/released/repeat out).

Verification
REQ-033 Scenario: with defaults, START (bit 3) held from frame 0. Required: pressed[3] at frame 1 events_valid, never earlier.
REQ-034 Scenario: START held 40 frames. Required: btn_repeat[3] at frames 31 and 37 only, exactly one pressed, no repeat on the press frame.
REQ-035 Scenario: a 1-frame glitch on UP (bit 4) with DEBOUNCE_FRAMES=2. Required: no pressed/released and btn_state[4] stays 0.
REQ-036 Scenario: buttons 0xFFF held, then is_present dropped. Required: btn_released = 0xFFF two frames later and btn_state = 0.
REQ-037 Scenario: frame_tick at T and T+5. Required: overrun at T+5 only, and a single events_valid at T+13.
REQ-038 Scenario: rst_n low at T+6 of a scan. Required: no events_valid, all outputs 0, and the next tick behaves as the first after reset.

Source files
------------

// File: rtl/gamepad_pkg.sv
// gamepad_pkg: shared button indices, repeat-state encoding and counter widths
// for the gamepad event generator.
package gamepad_pkg;
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam int DEB_W   = 2;
    localparam int REP_W   = 6;
    localparam int RSTAT_W = 2;

    typedef enum logic [RSTAT_W-1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_t;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_SCAN = 1'b1
    } ctrl_state_t;
endpackage

// File: rtl/gamepad_btn_update.sv
// gamepad_btn_update: one button's debounce and auto-repeat step for one frame;
// purely combinational so a single copy can be shared by all lanes.
module gamepad_btn_update
    import gamepad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 6
) (
    input  logic               raw,
    input  logic               stable,
    input  logic [DEB_W-1:0]   deb_cnt,
    input  logic [RSTAT_W-1:0] rep_st,
    input  logic [REP_W-1:0]   rep_cnt,
    output logic               stable_n,
    output logic [DEB_W-1:0]   deb_cnt_n,
    output logic [RSTAT_W-1:0] rep_st_n,
    output logic [REP_W-1:0]   rep_cnt_n,
    output logic               pressed,
    output logic               released,
    output logic               rpt
);
    localparam logic [DEB_W:0] DEB_LIM = (DEB_W+1)'(DEBOUNCE_FRAMES);
    localparam logic [REP_W:0] DLY_LIM = (REP_W+1)'(REPEAT_DELAY);
    localparam logic [REP_W:0] RATE_LIM = (REP_W+1)'(REPEAT_RATE);

    logic [DEB_W:0] deb_inc;
    logic [REP_W:0] rep_inc;
    logic [REP_W:0] rep_lim;
    logic           flip;
    logic           held;

    assign deb_inc  = {1'b0, deb_cnt} + 1'b1;
    assign rep_inc  = {1'b0, rep_cnt} + 1'b1;
    assign flip     = (raw != stable) && (deb_inc == DEB_LIM);
    assign stable_n = flip ? raw : stable;
    assign deb_cnt_n = (raw == stable || flip) ? '0 : deb_inc[DEB_W-1:0];
    assign pressed  = flip && raw;
    assign released = flip && !raw;

    // a release frame never counts toward a repeat
    assign held     = stable && !flip && rep_st != REP_IDLE;
    assign rep_lim  = (rep_st == REP_DELAY) ? DLY_LIM : RATE_LIM;
    assign rpt      = held && rep_inc == rep_lim;

    assign rep_st_n  = pressed ? REP_DELAY : released ? REP_IDLE : rpt ? REP_REPEAT : rep_st;
    assign rep_cnt_n = (flip || rpt) ? '0 : held ? rep_inc[REP_W-1:0] : rep_cnt;
endmodule

// File: rtl/gamepad_event_gen.sv
// gamepad_event_gen: per-frame debounce/auto-repeat event generator that scans
// one button per cycle through a shared update datapath.
module gamepad_event_gen
    import gamepad_pkg::*;
#(
    parameter int NUM_BUTTONS     = 12,
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] buttons_raw,
    input  logic                   is_present,
    input  logic                   frame_tick,
    output logic [NUM_BUTTONS-1:0] btn_state,
    output logic [NUM_BUTTONS-1:0] btn_pressed,
    output logic [NUM_BUTTONS-1:0] btn_released,
    output logic [NUM_BUTTONS-1:0] btn_repeat,
    output logic                   events_valid,
    output logic                   overrun
);
    localparam int IDX_W = NUM_BUTTONS > 1 ? $clog2(NUM_BUTTONS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BUTTONS - 1);

    ctrl_state_t state, state_n;
    logic [IDX_W-1:0] idx;
    logic [NUM_BUTTONS-1:0] snap, stable, p_acc, r_acc, rp_acc;
    logic [NUM_BUTTONS-1:0] st_v, p_v, r_v, rp_v;
    logic [DEB_W-1:0]   deb_cnt [NUM_BUTTONS];
    logic [RSTAT_W-1:0] rep_st  [NUM_BUTTONS];
    logic [REP_W-1:0]   rep_cnt [NUM_BUTTONS];
    logic busy, start, last, scan;
    logic stb_n, prs, rls, rpt;
    logic [DEB_W-1:0]   deb_n;
    logic [RSTAT_W-1:0] rst_st_n;
    logic [REP_W-1:0]   rep_n;

    // the events_valid cycle still counts as busy so a tick there is an overrun
    assign busy    = state == CTRL_SCAN || events_valid;
    assign start   = frame_tick && !busy;
    assign scan    = state == CTRL_SCAN;
    assign last    = idx == LAST;
    assign overrun = rst_n && frame_tick && busy;

    always_comb begin
        state_n = state;
        state_n = scan ? (last ? CTRL_IDLE : CTRL_SCAN) : (start ? CTRL_SCAN : CTRL_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= CTRL_IDLE;
        else        state <= state_n;
    end

    gamepad_btn_update #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_upd (
        .raw      (snap[idx]),
        .stable   (stable[idx]),
        .deb_cnt  (deb_cnt[idx]),
        .rep_st   (rep_st[idx]),
        .rep_cnt  (rep_cnt[idx]),
        .stable_n (stb_n),
        .deb_cnt_n(deb_n),
        .rep_st_n (rst_st_n),
        .rep_cnt_n(rep_n),
        .pressed  (prs),
        .released (rls),
        .rpt      (rpt)
    );

    always_comb begin
        st_v = stable;
        p_v  = p_acc;
        r_v  = r_acc;
        rp_v = rp_acc;
        st_v[idx] = stb_n;
        p_v[idx]  = prs;
        r_v[idx]  = rls;
        rp_v[idx] = rpt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx          <= '0;
            snap         <= '0;
            stable       <= '0;
            p_acc        <= '0;
            r_acc        <= '0;
            rp_acc       <= '0;
            btn_state    <= '0;
            btn_pressed  <= '0;
            btn_released <= '0;
            btn_repeat   <= '0;
            events_valid <= 1'b0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                deb_cnt[i] <= '0;
                rep_st[i]  <= REP_IDLE;
                rep_cnt[i] <= '0;
            end
        end else begin
            events_valid <= scan && last;
            if (start) begin
                snap   <= buttons_raw & {NUM_BUTTONS{is_present}};
                idx    <= '0;
                p_acc  <= '0;
                r_acc  <= '0;
                rp_acc <= '0;
            end
            if (scan) begin
                idx          <= idx + 1'b1;
                stable       <= st_v;
                p_acc        <= p_v;
                r_acc        <= r_v;
                rp_acc       <= rp_v;
                deb_cnt[idx] <= deb_n;
                rep_st[idx]  <= rst_st_n;
                rep_cnt[idx] <= rep_n;
                if (last) begin
                    btn_state    <= st_v;
                    btn_pressed  <= p_v;
                    btn_released <= r_v;
                    btn_repeat   <= rp_v;
                end
            end
        end
    end
endmodule

// File: tb/tb_gamepad_event_gen.sv
// tb_gamepad_event_gen: directed vector table plus hand-written multi-cycle
// sequences for repeat timing, overrun and mid-scan reset.
module tb_gamepad_event_gen;
    localparam int N = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] buttons_raw = '0;
    logic         is_present = 1'b0;
    logic         frame_tick = 1'b0;
    logic [N-1:0] btn_state, btn_pressed, btn_released, btn_repeat;
    logic         events_valid, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [11:0] raw;
        logic        pres;
        logic [11:0] st;
        logic [11:0] pr;
        logic [11:0] rl;
        logic [11:0] rp;
    } vec_t;

    vec_t tbl [14];

    gamepad_event_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .buttons_raw (buttons_raw),
        .is_present  (is_present),
        .frame_tick  (frame_tick),
        .btn_state   (btn_state),
        .btn_pressed (btn_pressed),
        .btn_released(btn_released),
        .btn_repeat  (btn_repeat),
        .events_valid(events_valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [11:0] st, input logic [11:0] pr,
                            input logic [11:0] rl, input logic [11:0] rp);
        chk({tag, "_state"}, 32'(btn_state), 32'(st));
        chk({tag, "_pressed"}, 32'(btn_pressed), 32'(pr));
        chk({tag, "_released"}, 32'(btn_released), 32'(rl));
        chk({tag, "_repeat"}, 32'(btn_repeat), 32'(rp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one frame: tick, then wait (bounded) for events_valid; returns at a negedge inside that cycle
    task automatic do_frame(input logic [11:0] raw, input logic pres);
        int n;
        @(negedge clk);
        buttons_raw = raw;
        is_present  = pres;
        frame_tick  = 1'b1;
        @(negedge clk);
        frame_tick  = 1'b0;
        buttons_raw = ~raw;
        n = 0;
        while (!events_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("frame_latency", 32'(n), 32'd12);
    endtask

    task automatic run_ticks(input int t2);
        int ov_n, ov_at, ev_n, ev_at;
        ov_n = 0; ov_at = -1; ev_n = 0; ev_at = -1;
        buttons_raw = 12'h008;
        is_present  = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            frame_tick = (c == 0 || c == t2);
            #1;
            if (overrun) begin ov_n++; ov_at = c; end
            if (events_valid) begin ev_n++; ev_at = c; end
        end
        frame_tick = 1'b0;
        chk($sformatf("ovr%0d_count", t2), 32'(ov_n), 32'd1);
        chk($sformatf("ovr%0d_at", t2), 32'(ov_at), 32'(t2));
        chk($sformatf("ovr%0d_ev_count", t2), 32'(ev_n), 32'd1);
        chk($sformatf("ovr%0d_ev_at", t2), 32'(ev_at), 32'd13);
        chk($sformatf("ovr%0d_state", t2), 32'(btn_state), 32'h008);
    endtask

    initial begin
        tbl[0]  = '{12'h008, 1'b1, 12'h000, 12'h000, 12'h000, 12'h000};
        tbl[1]  = '{12'h008, 1'b1, 12'h008, 12'h008, 12'h000, 12'h000};
        tbl[2]  = '{12'h018, 1'b1, 12'h008, 12'h000, 12'h000, 12'h000};
        tbl[3]  = '{12'h008, 1'b1, 12'h008, 12'h000, 12'h000, 12'h000};
        tbl[4]  = '{12'h000, 1'b1, 12'h008, 12'h000, 12'h000, 12'h000};
        tbl[5]  = '{12'h000, 1'b1, 12'h000, 12'h000, 12'h008, 12'h000};
        tbl[6]  = '{12'h101, 1'b1, 12'h000, 12'h000, 12'h000, 12'h000};
        tbl[7]  = '{12'h101, 1'b1, 12'h101, 12'h101, 12'h000, 12'h000};
        tbl[8]  = '{12'h101, 1'b0, 12'h101, 12'h000, 12'h000, 12'h000};
        tbl[9]  = '{12'hFFF, 1'b0, 12'h000, 12'h000, 12'h101, 12'h000};
        tbl[10] = '{12'hFFF, 1'b1, 12'h000, 12'h000, 12'h000, 12'h000};
        tbl[11] = '{12'hFFF, 1'b1, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
        tbl[12] = '{12'hFFF, 1'b0, 12'hFFF, 12'h000, 12'h000, 12'h000};
        tbl[13] = '{12'hFFF, 1'b0, 12'h000, 12'h000, 12'hFFF, 12'h000};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_outs("reset", '0, '0, '0, '0);
        chk("reset_valid", 32'(events_valid), 32'd0);

        for (int i = 0; i < 14; i++) begin
            do_frame(tbl[i].raw, tbl[i].pres);
            chk_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].pr, tbl[i].rl, tbl[i].rp);
        end

        // START held for 40 frames from a fresh reset
        do_reset();
        for (int f = 0; f < 40; f++) begin
            do_frame(12'h008, 1'b1);
            chk($sformatf("hold%0d_pressed", f), 32'(btn_pressed), (f == 1) ? 32'h008 : 32'h0);
            chk($sformatf("hold%0d_repeat", f), 32'(btn_repeat), (f == 31 || f == 37) ? 32'h008 : 32'h0);
        end

        run_ticks(5);
        run_ticks(13);

        // reset in the middle of a scan, with a tick coincident with reset
        begin
            int ev_n;
            ev_n = 0;
            buttons_raw = 12'h008;
            for (int c = 0; c < 35; c++) begin
                @(negedge clk);
                frame_tick = (c == 0 || c == 6);
                rst_n = (c != 6);
                #1;
                if (events_valid) ev_n++;
            end
            frame_tick = 1'b0;
            rst_n = 1'b1;
            chk("rstscan_ev_count", 32'(ev_n), 32'd0);
            chk_outs("rstscan", '0, '0, '0, '0);
        end
        do_frame(12'h008, 1'b1);
        chk_outs("after_rst0", 12'h000, 12'h000, 12'h000, 12'h000);
        do_frame(12'h008, 1'b1);
        chk_outs("after_rst1", 12'h008, 12'h008, 12'h000, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
